// File: rtl/product_accumulator.sv
// Streaming multiply-accumulate: operand pairs are multiplied by a carry-save
// multiplier, registered, and summed per vector into a saturating accumulator.

module multiplier_csa #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  logic [2*N-1:0] sum_v, car_v, pp, nxt_s, nxt_c;

  // Partial products are folded into a redundant sum/carry pair; one final add resolves it.
  always_comb begin
    sum_v = '0;
    car_v = '0;
    pp    = '0;
    nxt_s = '0;
    nxt_c = '0;
    for (int i = 0; i < N; i++) begin
      pp    = {{N{1'b0}}, a & {N{b[i]}}} << i;
      nxt_s = sum_v ^ car_v ^ pp;
      nxt_c = ((sum_v & car_v) | (sum_v & pp) | (car_v & pp)) << 1;
      sum_v = nxt_s;
      car_v = nxt_c;
    end
    p = sum_v + car_v;
  end
endmodule

module product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       term_count,
  output logic             overflow
);
  typedef enum logic {S_ACC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2*N-1:0]   prod;
  logic [2*N-1:0]   prod_p1_q;
  logic             vld_p1_q, last_p1_q;
  logic             last_pending_q, last_pending_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [7:0]       cnt_out_q, cnt_out_d;
  logic             ovf_out_q, ovf_out_d;
  logic [ACC_W:0]   add_res;
  logic             accept;

  // Returns {carry, value}; on carry the value is pinned to all ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [2*N-1:0]   p);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W+1-2*N){1'b0}}, p};
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  multiplier_csa #(.N(N)) u_mul (.a(a), .b(b), .p(prod));

  assign in_ready   = rst_n && (state_q == S_ACC) && !last_pending_q;
  assign accept     = in_valid && in_ready;
  assign add_res    = sat_add(acc_q, prod_p1_q);
  assign out_valid  = out_valid_q;
  assign acc_out    = acc_out_q;
  assign term_count = cnt_out_q;
  assign overflow   = ovf_out_q;

  always_comb begin
    state_d        = state_q;
    last_pending_d = last_pending_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    out_valid_d    = out_valid_q;
    acc_out_d      = acc_out_q;
    cnt_out_d      = cnt_out_q;
    ovf_out_d      = ovf_out_q;
    if (accept && in_last) last_pending_d = 1'b1;
    case (state_q)
      S_ACC: begin
        if (vld_p1_q) begin
          acc_d = add_res[ACC_W-1:0];
          ovf_d = ovf_q | add_res[ACC_W];
          cnt_d = sat_inc8(cnt_q);
          if (last_p1_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            acc_out_d   = acc_d;
            cnt_out_d   = cnt_d;
            ovf_out_d   = ovf_d;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d        = S_ACC;
          out_valid_d    = 1'b0;
          acc_d          = '0;
          cnt_d          = '0;
          ovf_d          = 1'b0;
          last_pending_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // Stage 1: product register (data only, qualified by vld_p1_q)
  always_ff @(posedge clk) begin
    if (accept) prod_p1_q <= prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_ACC;
      vld_p1_q       <= 1'b0;
      last_p1_q      <= 1'b0;
      last_pending_q <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      acc_out_q      <= '0;
      cnt_out_q      <= '0;
      ovf_out_q      <= 1'b0;
    end else begin
      vld_p1_q       <= accept;
      last_p1_q      <= accept && in_last;
      // Stage 2: accumulate and result capture
      state_q        <= state_d;
      last_pending_q <= last_pending_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      out_valid_q    <= out_valid_d;
      acc_out_q      <= acc_out_d;
      cnt_out_q      <= cnt_out_d;
      ovf_out_q      <= ovf_out_d;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator against a dot-product model.

module tb_product_accumulator;
  localparam int N     = 4;
  localparam int ACC_W = 12;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic [7:0]       term_count;
  logic             overflow;

  int n_vec = 0;
  int n_bad = 0;
  int va[$];
  int vb[$];

  product_accumulator #(.N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .term_count(term_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one beat and returns 1 ns after the edge that accepted it.
  task automatic send_beat(input int av, input int bv, input bit last);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    a = N'(av);
    b = N'(bv);
    in_last = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Sends va/vb as one vector, with a bubble of up to max_gap cycles between beats.
  task automatic send_vector(input int max_gap);
    for (int i = 0; i < va.size(); i++) begin
      send_beat(va[i], vb[i], i == va.size() - 1);
      if (i != va.size() - 1 && max_gap > 0 && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, max_gap));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int hold);
    longint sum;
    int     exp_acc, exp_cnt, exp_ovf;
    bit     seen;
    logic [ACC_W-1:0] acc_s;
    logic [7:0]       cnt_s;
    logic             ovf_s;
    sum = 0;
    for (int i = 0; i < va.size(); i++) sum += longint'(va[i]) * vb[i];
    exp_acc = (sum > MAXV) ? MAXV : int'(sum);
    exp_ovf = (sum > MAXV) ? 1 : 0;
    exp_cnt = (va.size() > 255) ? 255 : va.size();
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_acc"}, acc_out, exp_acc);
    chk({tag, "_cnt"}, term_count, exp_cnt);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    acc_s = acc_out;
    cnt_s = term_count;
    ovf_s = overflow;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, out_valid, 1);
      chk({tag, "_hold_acc"}, acc_out, acc_s);
      chk({tag, "_hold_cnt"}, term_count, cnt_s);
      chk({tag, "_hold_ovf"}, overflow, ovf_s);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  task automatic set_vec1(input int av, input int bv);
    va.delete();
    vb.delete();
    va.push_back(av);
    vb.push_back(bv);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_cnt", term_count, 0);
    chk("rst_ovf", overflow, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Single term with latency check
    set_vec1(15, 15);
    send_beat(15, 15, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("single_lat_vld0", out_valid, 0);
    chk("single_rdy_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("single_lat_vld1", out_valid, 1);
    expect_result("single", 0);

    // Four-term vector at full rate
    va = '{3, 2, 15, 0};
    vb = '{5, 7, 1, 9};
    send_vector(0);
    chk("four_rdy_low", in_ready, 0);
    expect_result("four", 0);

    // Backpressure, then a residue check
    va = '{6, 9};
    vb = '{11, 13};
    send_vector(0);
    expect_result("bp", 5);
    set_vec1(1, 1);
    send_vector(0);
    expect_result("after_bp", 0);

    // Saturation, then recovery
    va.delete();
    vb.delete();
    for (int i = 0; i < 19; i++) begin
      va.push_back(15);
      vb.push_back(15);
    end
    send_vector(0);
    expect_result("sat", 1);
    set_vec1(2, 3);
    send_vector(0);
    expect_result("after_sat", 0);

    // Bubbles inside a vector
    send_beat(4, 4, 1'b0);
    idle(3);
    va = '{4, 5};
    vb = '{4, 5};
    send_beat(5, 5, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("bubble", 0);

    // Term counter saturation
    va.delete();
    vb.delete();
    for (int i = 0; i < 300; i++) begin
      va.push_back(1);
      vb.push_back(1);
    end
    send_vector(0);
    expect_result("cnt_sat", 0);

    // Randomized vectors
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 24);
      va.delete();
      vb.delete();
      for (int i = 0; i < len; i++) begin
        va.push_back($urandom_range(0, 15));
        vb.push_back($urandom_range(0, 15));
      end
      send_vector(3);
      expect_result("rand", $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a vector
    send_beat(7, 7, 1'b0);
    send_beat(7, 7, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_cnt", term_count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_vec1(1, 2);
    send_vector(0);
    expect_result("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
